mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (instruction port, IF) and the memory stage (data port, DM) of the Y86 pipeline.
- Sequences one transaction at a time through a ready/valid memory interface with variable latency.
- Drives per-port stall signals that feed the pipeline control unit (F_stall / W_stall / M_bubble generation).
- Reports per-port address errors, including timeouts, so the stage can raise stat SADR (4'b0011).

Parameters:
ADDR_W, 64, address width in bits
DATA_W, 64, data word width in bits
MAX_DM_RUN, 4, max consecutive DM grants while IF is waiting (starvation guard), range 1..15
TIMEOUT, 64, cycles in WAIT without mem_rvalid before the transaction is aborted with error, range 2..255

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
if_req  in  1  instruction read request; held until if_done
if_addr  in  ADDR_W  instruction address
if_rdata  out  DATA_W  instruction word, valid while if_done=1
if_done  out  1  one-cycle completion pulse for IF
if_err  out  1  IF error, valid while if_done=1
if_stall  out  1  IF stall = if_req & ~if_done (combinational)
dm_req  in  1  data request; held until dm_done
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  read data, valid while dm_done=1
dm_done  out  1  one-cycle completion pulse for DM
dm_err  out  1  DM error, valid while dm_done=1
dm_stall  out  1  DM stall = dm_req & ~dm_done (combinational)
mem_valid  out  1  request valid to backing memory
mem_we  out  1  write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  response valid (read data or write ack)
mem_rdata  in  DATA_W  response data
mem_err  in  1  response error, qualified by mem_rvalid

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, run_cnt=0, timeout counter=0. All registered outputs go to 0: mem_valid, mem_we, mem_addr, mem_wdata, *_done, *_err, *_rdata.
- Reset mid-transaction aborts the transaction with no done pulse. mem_rvalid arriving in IDLE is ignored.
- States and transitions:
  - IDLE: arbitrate.
    - Grant DM if dm_req & (~if_req | run_cnt<MAX_DM_RUN); else grant IF if if_req.
    - On grant, latch owner, addr, we (IF: we=0) and wdata, then go to REQ.
  - REQ: mem_valid=1 with the latched fields, held stable until mem_ready. On mem_ready go to WAIT and clear the timeout counter.
  - WAIT:
    - mem_rvalid -> latch mem_rdata (0 for writes) and err=mem_err, go to RESP.
    - Counter reaching TIMEOUT -> rdata=0, err=1, go to RESP.
    - mem_rvalid in the same cycle as the final count wins (no error unless mem_err).
  - RESP: owner's *_done=1 for exactly one cycle with rdata/err. Next state IDLE.
- Latency: minimum 4 cycles from req seen in IDLE to done (grant, REQ+ready, WAIT+rvalid, RESP). No back-to-back overlap; at most one outstanding transaction.
- run_cnt:
  - +1 (saturating at 15) on each DM grant while if_req=1.
  - Cleared on an IF grant, or in IDLE when if_req=0.
- Simultaneous if_req and dm_req with run_cnt<MAX_DM_RUN: DM wins (older instruction first).
- Requester dropping req mid-transaction: the memory transaction still completes and the done pulse is suppressed. Latched fields never change after grant.
- A new req in the RESP cycle is arbitrated in the following IDLE cycle.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with if_req=1 -> mem_valid=0, if_done=0, if_stall=1. After release, mem_valid=1 at cycle 2 with mem_addr=if_addr.
- IF read: if_addr=0x100, mem_ready immediate, mem_rvalid 1 cycle later with rdata=0x30F2_0A00 -> if_done pulses one cycle at cycle 4 with if_rdata=0x30F2_0A00, if_err=0, then if_stall falls.
- Contention: if_req and dm_req held continuously, MAX_DM_RUN=4 -> grant order DM,DM,DM,DM,IF,DM..., IF never starved.
- DM write: dm_we=1, addr=0x200, wdata=0xDEAD_BEEF, mem_ready delayed 3 cycles -> mem_valid/mem_addr/mem_wdata stable for 4 cycles. dm_done after ack with dm_rdata=0.
- Error/timeout: TIMEOUT=8, no mem_rvalid -> dm_done with dm_err=1 after exactly 8 WAIT cycles. Separately, mem_rvalid with mem_err=1 -> if_err=1.
- Reset mid-WAIT: assert rst_n=0 during WAIT, late mem_rvalid arrives after reset -> no done pulse, state IDLE, next request serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch (IF) and data-memory (DM) ports of the Y86
// pipeline onto one single-ported, variable-latency backing memory.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MAX_DM_RUN = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    output logic              if_stall,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_err,
    output logic              dm_stall,

    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,

    output logic [1:0]        dbg_state
);

    // Memory handshake: a request transfers on a cycle where mem_valid and
    // mem_ready are both high; mem_valid/we/addr/wdata hold steady until then.
    // A response is one cycle with mem_rvalid high; mem_rdata/mem_err only
    // mean something in that cycle. One transaction is outstanding at a time.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_dm;
    logic [3:0]        run_cnt;
    logic [7:0]        to_cnt;

    logic              grant_dm;
    logic              grant_if;
    logic              timeout_hit;
    logic              resp_fire;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // DM normally wins a tie; the run counter bounds how long IF can be held off.
    assign grant_dm    = dm_req & (~if_req | (run_cnt < 4'(MAX_DM_RUN)));
    assign grant_if    = if_req & ~grant_dm;
    assign timeout_hit = (to_cnt == 8'(TIMEOUT - 1));
    assign resp_fire   = mem_rvalid | timeout_hit;

    // A real response beats a timeout landing on the same cycle.
    assign resp_rdata  = (mem_rvalid && !mem_we) ? mem_rdata : '0;
    assign resp_err    = mem_rvalid ? mem_err : 1'b1;

    assign if_stall  = if_req & ~if_done;
    assign dm_stall  = dm_req & ~dm_done;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (grant_dm || grant_if) state_nxt = S_REQ;
            S_REQ:  if (mem_ready)            state_nxt = S_WAIT;
            S_WAIT: if (resp_fire)            state_nxt = S_RESP;
            S_RESP:                           state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner_dm  <= 1'b0;
            run_cnt   <= '0;
            to_cnt    <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            state   <= state_nxt;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_dm) begin
                        owner_dm  <= 1'b1;
                        mem_valid <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_if) begin
                        owner_dm  <= 1'b0;
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                    if (grant_if || !if_req) begin
                        run_cnt <= '0;
                    end else if (grant_dm && run_cnt != 4'hF) begin
                        run_cnt <= run_cnt + 4'd1;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        to_cnt    <= '0;
                    end
                end
                S_WAIT: begin
                    if (resp_fire) begin
                        // A requester that has let go of its req gets no pulse.
                        if (owner_dm) begin
                            dm_done  <= dm_req;
                            dm_rdata <= resp_rdata;
                            dm_err   <= resp_err;
                        end else begin
                            if_done  <= if_req;
                            if_rdata <= resp_rdata;
                            if_err   <= resp_err;
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions against a scripted
// memory responder, then contention, dropped-request and reset-in-WAIT sequences.
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXR = 4;
    localparam int TO   = 8;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_err;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          dm_err;
    logic          dm_stall;
    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          mem_err;
    logic [1:0]    dbg_state;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DM_RUN(MAXR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err), .dm_stall(dm_stall),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          rdy_dly;
        int          rv_dly;
        bit          rsp_none;
        bit          rsp_err;
        logic [63:0] rsp_data;
        logic [63:0] exp_rdata;
        bit          exp_err;
        int          exp_steps;
    } vec_t;

    int            checks;
    int            errors;
    logic [DW:0]   if_q[$];
    logic [DW:0]   dm_q[$];
    int            if_done_cnt;
    int            dm_done_cnt;

    int            rsp_ready_dly;
    int            rsp_rv_dly;
    bit            rsp_none;
    bit            rsp_err;
    logic [DW-1:0] rsp_data;
    int            r_phase;
    int            r_cnt;

    bit            chk_fields;
    bit            cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    bit            log_grants;
    logic [AW-1:0] grant_log[$];

    vec_t          vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: scoreboard on done pulses, then the scripted memory responder.
    task automatic step();
        logic [DW:0] e;
        @(posedge clk);
        #1;
        if (if_done) begin
            if_done_cnt++;
            check("if_done_expected", 64'(if_q.size() != 0), 64'd1);
            if (if_q.size() != 0) begin
                e = if_q.pop_front();
                check("if_rdata", if_rdata, e[DW:1]);
                check("if_err", 64'(if_err), 64'(e[0]));
            end
        end
        if (dm_done) begin
            dm_done_cnt++;
            check("dm_done_expected", 64'(dm_q.size() != 0), 64'd1);
            if (dm_q.size() != 0) begin
                e = dm_q.pop_front();
                check("dm_rdata", dm_rdata, e[DW:1]);
                check("dm_err", 64'(dm_err), 64'(e[0]));
            end
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = {$urandom, $urandom};
        if (r_phase == 0 && mem_valid) begin
            r_phase = 1;
            r_cnt   = 0;
            if (log_grants) grant_log.push_back(mem_addr);
        end
        if (r_phase == 1) begin
            if (chk_fields) begin
                check("req_valid_held", 64'(mem_valid), 64'd1);
                check("req_addr_held", mem_addr, cur_addr);
                check("req_wdata_held", mem_wdata, cur_wdata);
                check("req_we_held", 64'(mem_we), 64'(cur_we));
            end
            if (r_cnt == rsp_ready_dly) begin
                mem_ready = 1'b1;
                r_phase   = 2;
                r_cnt     = 0;
            end else begin
                r_cnt++;
            end
        end else if (r_phase == 2) begin
            if (rsp_none) begin
                r_phase = 0;
            end else if (r_cnt == rsp_rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_data;
                mem_err    = rsp_err;
                r_phase    = 0;
            end else begin
                r_cnt++;
            end
        end
    endtask

    // Steps until the owner's done pulse (bounded) and checks the latency.
    task automatic wait_done(input bit is_dm, input int n0, input int exp_steps);
        int n;
        bit seen;
        n    = n0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            step();
            n++;
            seen = is_dm ? dm_done : if_done;
            if (!seen) check("stall_while_busy", 64'(is_dm ? dm_stall : if_stall), 64'd1);
        end
        check("done_latency", 64'(n), 64'(exp_steps));
        check("stall_at_done", 64'(is_dm ? dm_stall : if_stall), 64'd0);
    endtask

    task automatic cfg_rsp(input int rdy, input int rv, input bit none, input bit err,
                           input logic [63:0] data);
        rsp_ready_dly = rdy;
        rsp_rv_dly    = rv;
        rsp_none      = none;
        rsp_err       = err;
        rsp_data      = data;
    endtask

    task automatic run_vec(input vec_t v);
        cfg_rsp(v.rdy_dly, v.rv_dly, v.rsp_none, v.rsp_err, v.rsp_data);
        cur_addr   = v.addr;
        cur_we     = v.is_dm ? v.we : 1'b0;
        cur_wdata  = v.is_dm ? v.wdata : '0;
        chk_fields = 1'b1;
        if (v.is_dm) begin
            dm_q.push_back({v.exp_rdata, v.exp_err});
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_q.push_back({v.exp_rdata, v.exp_err});
            if_req = 1'b1; if_addr = v.addr;
        end
        wait_done(v.is_dm, 0, v.exp_steps);
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        check("back_to_idle", 64'(dbg_state), 64'd0);
        chk_fields = 1'b0;
    endtask

    function automatic vec_t mk(bit is_dm, bit we, logic [63:0] addr, logic [63:0] wdata,
                                int rdy, int rv, bit none, bit err, logic [63:0] data,
                                logic [63:0] exp_rdata, bit exp_err, int steps);
        vec_t v;
        v.is_dm = is_dm; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rdy_dly = rdy; v.rv_dly = rv; v.rsp_none = none; v.rsp_err = err;
        v.rsp_data = data; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_steps = steps;
        return v;
    endfunction

    initial begin
        logic [63:0] rnd;
        logic [63:0] exp_order[10];
        int          s_if;
        int          s_dm;
        int          n;

        checks = 0; errors = 0; if_done_cnt = 0; dm_done_cnt = 0;
        r_phase = 0; r_cnt = 0; chk_fields = 1'b0; log_grants = 1'b0;
        cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
        cfg_rsp(0, 0, 1'b0, 1'b0, 64'h0);
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;

        // {is_dm, we, addr, wdata, rdy, rv, none, err, rsp_data, exp_rdata, exp_err, steps}
        rnd = {$urandom, $urandom};
        vecs[0] = mk(0, 0, 64'h100, 64'h0,        0, 0, 0, 0, 64'h30F2_0A00, 64'h30F2_0A00, 0, 3);
        vecs[1] = mk(1, 1, 64'h200, 64'hDEAD_BEEF, 3, 0, 0, 0, 64'h1234, 64'h0, 0, 6);
        vecs[2] = mk(1, 0, 64'h208, 64'h99,       1, 2, 0, 0, 64'hCAFE_F00D_1234_5678,
                     64'hCAFE_F00D_1234_5678, 0, 6);
        vecs[3] = mk(1, 0, 64'h210, 64'h0,        0, 0, 1, 0, 64'hFFFF, 64'h0, 1, 10);
        vecs[4] = mk(0, 0, 64'h108, 64'h0,        0, 1, 0, 1, 64'h55, 64'h55, 1, 4);
        vecs[5] = mk(1, 0, 64'h218, 64'h0,        0, 7, 0, 0, 64'h0123_4567_89AB_CDEF,
                     64'h0123_4567_89AB_CDEF, 0, 10);
        vecs[6] = mk(0, 0, 64'h110, 64'h0,        2, 3, 0, 0, rnd, rnd, 0, 8);
        vecs[7] = mk(1, 1, 64'h220, 64'h77,       0, 0, 0, 1, 64'hABCD, 64'h0, 1, 3);
        vecs[8] = mk(1, 0, 64'h228, 64'h0,        2, 0, 1, 0, 64'h1, 64'h0, 1, 12);
        vecs[9] = mk(0, 0, 64'h118, 64'h0,        0, 0, 0, 0, 64'h600D, 64'h600D, 0, 3);

        // reset with IF already requesting, then the first grant
        if_req = 1'b1; if_addr = 64'h100;
        step();
        step();
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_if_done", 64'(if_done), 64'd0);
        check("rst_if_stall", 64'(if_stall), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        cfg_rsp(0, 0, 1'b0, 1'b0, 64'h30F2_0A00);
        cur_addr = 64'h100; cur_we = 1'b0; cur_wdata = '0; chk_fields = 1'b1;
        if_q.push_back({64'h30F2_0A00, 1'b0});
        rst_n = 1'b1;
        step();
        check("first_grant_valid", 64'(mem_valid), 64'd1);
        check("first_grant_addr", mem_addr, 64'h100);
        wait_done(1'b0, 1, 3);
        if_req = 1'b0;
        step();
        chk_fields = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // IF and DM both hold requests: DM x4, IF, DM x4, IF
        cfg_rsp(0, 0, 1'b0, 1'b0, 64'h77);
        repeat (8) dm_q.push_back({64'h77, 1'b0});
        repeat (2) if_q.push_back({64'h77, 1'b0});
        grant_log.delete();
        log_grants = 1'b1;
        s_if = if_done_cnt; s_dm = dm_done_cnt;
        if_addr = 64'h1000; dm_addr = 64'h2000; dm_we = 1'b0; dm_wdata = '0;
        if_req = 1'b1; dm_req = 1'b1;
        n = 0;
        while (if_done_cnt - s_if < 2 && n < 200) begin
            step();
            n++;
        end
        if_req = 1'b0; dm_req = 1'b0;
        log_grants = 1'b0;
        step();
        step();
        check("cont_if_dones", 64'(if_done_cnt - s_if), 64'd2);
        check("cont_dm_dones", 64'(dm_done_cnt - s_dm), 64'd8);
        check("cont_grant_count", 64'(grant_log.size()), 64'd10);
        for (int i = 0; i < 10; i++) exp_order[i] = (i == 4 || i == 9) ? 64'h1000 : 64'h2000;
        for (int i = 0; i < 10 && i < grant_log.size(); i++) check("cont_grant_order", grant_log[i], exp_order[i]);

        // DM drops its request mid-transaction: memory still completes, no pulse
        cfg_rsp(0, 2, 1'b0, 1'b0, 64'h42);
        s_dm = dm_done_cnt;
        dm_req = 1'b1; dm_addr = 64'h300; dm_we = 1'b0;
        step();
        step();
        dm_req = 1'b0;
        repeat (6) step();
        check("drop_no_done", 64'(dm_done_cnt - s_dm), 64'd0);
        check("drop_idle", 64'(dbg_state), 64'd0);

        // reset while in WAIT, with the response arriving after reset
        cfg_rsp(0, 5, 1'b0, 1'b0, 64'hBAD);
        s_dm = dm_done_cnt;
        dm_req = 1'b1; dm_addr = 64'h308; dm_we = 1'b0;
        step();
        step();
        step();
        check("pre_rst_wait", 64'(dbg_state), 64'd2);
        rst_n = 1'b0; dm_req = 1'b0;
        step();
        check("mid_rst_valid", 64'(mem_valid), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("late_rvalid_no_done", 64'(dm_done_cnt - s_dm), 64'd0);
        check("late_rvalid_idle", 64'(dbg_state), 64'd0);
        run_vec(vecs[9]);

        check("if_q_drained", 64'(if_q.size()), 64'd0);
        check("dm_q_drained", 64'(dm_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
